decode_stage: RTL and testbench

Parametrised decode stage for the MIPS pipeline, between the IF/ID register and the execute stage. It contains the register file with write-through bypass, load-use and branch-operand hazard detection, and early branch/jump resolution with operand forwarding from MEM. It drives a registered ID/EX boundary with valid, hold and flush control. Control decoding stays in `control`: its buses arrive here as inputs, already decoded from `in_instruccion`.

---
 rtl/decode_stage.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// MIPS pipeline decode stage. It sits between the IF/ID register and the
// execute stage and contains:
//   - a register file with combinational reads, where a write in the same
//     cycle as a read is returned directly (write-through bypass)
//   - load-use and branch-operand hazard detection
//   - early resolution of BEQ/BNE/J/JAL/JR, with branch operands forwarded
//     from the MEM stage
//   - the registered ID/EX boundary, with valid, hold and flush control
//
// Control decoding lives in the separate `control` block. Its buses arrive
// here already decoded from in_instruccion.
//
// Ports
//   clk, reset             rising-edge clock; asynchronous active-low reset
//   in_valid               IF/ID holds a real instruction
//   in_pc_branch           PC+4 of the instruction in ID
//   in_instruccion         instruction word in ID
//   in_exec/mem/wb_bus     decoded control buses for the instruction in ID
//   in_hold, in_flush      downstream freeze / squash of ID/EX
//   RegWrite,
//   write_register,
//   write_data             write-back port of the register file
//   ex_reg_write,
//   ex_mem_read, ex_dest   instruction currently in EX
//   mem_reg_write,
//   mem_mem_read,
//   mem_dest,
//   mem_fwd_data           instruction currently in MEM and its ALU result
//   out_*, execute_bus,
//   memory_bus,
//   writeBack_bus          registered ID/EX contents
//   stall_flag             combinational; IF and IF/ID must hold
//   redirect,
//   redirect_target        combinational fetch redirect (taken branch/jump)
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int len          = 32,
  parameter int n_regs       = 32,
  parameter int NB           = $clog2(n_regs),
  parameter int len_exec_bus = 11,
  parameter int len_mem_bus  = 9,
  parameter int len_wb_bus   = 2,
  parameter int mem_read_bit = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [len-1:0]          in_pc_branch,
  input  logic [len-1:0]          in_instruccion,
  input  logic [len_exec_bus-1:0] in_exec_bus,
  input  logic [len_mem_bus-1:0]  in_mem_bus,
  input  logic [len_wb_bus-1:0]   in_wb_bus,
  input  logic                    in_hold,
  input  logic                    in_flush,
  input  logic                    RegWrite,
  input  logic [NB-1:0]           write_register,
  input  logic [len-1:0]          write_data,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  input  logic [NB-1:0]           ex_dest,
  input  logic                    mem_reg_write,
  input  logic                    mem_mem_read,
  input  logic [NB-1:0]           mem_dest,
  input  logic [len-1:0]          mem_fwd_data,
  output logic                    out_valid,
  output logic [len-1:0]          out_pc_branch,
  output logic [len-1:0]          out_reg1,
  output logic [len-1:0]          out_reg2,
  output logic [len-1:0]          out_sign_extend,
  output logic [NB-1:0]           out_rs,
  output logic [NB-1:0]           out_rt,
  output logic [NB-1:0]           out_rd,
  output logic [NB-1:0]           out_shamt,
  output logic [len_exec_bus-1:0] execute_bus,
  output logic [len_mem_bus-1:0]  memory_bus,
  output logic [len_wb_bus-1:0]   writeBack_bus,
  output logic                    stall_flag,
  output logic                    redirect,
  output logic [len-1:0]          redirect_target
);

  // -------------------------------------------------------------------------
  // Elaboration-time sanity check: MemRead must lie inside the memory bus.
  // -------------------------------------------------------------------------
  if (mem_read_bit < 0 || mem_read_bit >= len_mem_bus) begin : g_bad_mem_read_bit
    $error("decode_stage: mem_read_bit outside the memory bus");
  end

  // -------------------------------------------------------------------------
  // Opcodes and functs that matter for early resolution
  // -------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ID/EX boundary contents, kept together so that hold, flush and bubble
  // all act on a single register.
  typedef struct packed {
    logic                    valid;
    logic [len-1:0]          pc_branch;
    logic [len-1:0]          reg1;
    logic [len-1:0]          reg2;
    logic [len-1:0]          sign_extend;
    logic [NB-1:0]           rs;
    logic [NB-1:0]           rt;
    logic [NB-1:0]           rd;
    logic [NB-1:0]           shamt;
    logic [len_exec_bus-1:0] exec_bus;
    logic [len_mem_bus-1:0]  mem_bus;
    logic [len_wb_bus-1:0]   wb_bus;
  } idex_t;

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [5:0]     opcode;
  logic [5:0]     funct;
  logic [NB-1:0]  rs_idx;
  logic [NB-1:0]  rt_idx;
  logic [NB-1:0]  rd_idx;
  logic [NB-1:0]  shamt_f;
  logic [15:0]    imm16;
  logic [25:0]    imm26;
  logic [len-1:0] sext_imm;

  assign opcode   = in_instruccion[31:26];
  assign funct    = in_instruccion[5:0];
  assign rs_idx   = NB'(in_instruccion[25:21]);
  assign rt_idx   = NB'(in_instruccion[20:16]);
  assign rd_idx   = NB'(in_instruccion[15:11]);
  assign shamt_f  = NB'(in_instruccion[10:6]);
  assign imm16    = in_instruccion[15:0];
  assign imm26    = in_instruccion[25:0];
  assign sext_imm = {{(len-16){imm16[15]}}, imm16};

  logic is_beq, is_bne, is_j, is_jal, is_jr;

  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (opcode == OP_BNE);
  assign is_j   = (opcode == OP_J);
  assign is_jal = (opcode == OP_JAL);
  assign is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [len-1:0] regs_q [n_regs];

  // NOTE: the register file is cleared by reset. This costs a reset net on
  // every entry, but a freshly reset pipeline must read zeros and not
  // leftovers from before the reset.
  // NOTE: sequential state is assigned with non-blocking (<=) so that every
  // register samples its inputs from before the edge, whatever the order of
  // the always_ff blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < n_regs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RegWrite && (write_register != '0)) begin
      regs_q[write_register] <= write_data;
    end
  end

  // Write-through bypass: a write-back to the index being read in the same
  // cycle is returned directly. Entry 0 is never written, so it always reads 0.
  logic           wr_active;
  logic [len-1:0] rf_rs;
  logic [len-1:0] rf_rt;

  assign wr_active = RegWrite && (write_register != '0);
  assign rf_rs = (wr_active && (write_register == rs_idx)) ? write_data : regs_q[rs_idx];
  assign rf_rt = (wr_active && (write_register == rt_idx)) ? write_data : regs_q[rt_idx];

  // -------------------------------------------------------------------------
  // Decode-time operands for the branch comparator and the JR target.
  // MEM can forward only an ALU result. A load in MEM has no data yet, and
  // the hazard logic stalls on it instead.
  // -------------------------------------------------------------------------
  logic           mem_fwd_ok;
  logic [len-1:0] fwd_rs;
  logic [len-1:0] fwd_rt;

  assign mem_fwd_ok = mem_reg_write && !mem_mem_read;

  always_comb begin
    if (rs_idx == '0)                           fwd_rs = '0;
    else if (mem_fwd_ok && (mem_dest == rs_idx)) fwd_rs = mem_fwd_data;
    else                                        fwd_rs = rf_rs;

    if (rt_idx == '0)                           fwd_rt = '0;
    else if (mem_fwd_ok && (mem_dest == rt_idx)) fwd_rt = mem_fwd_data;
    else                                        fwd_rt = rf_rt;
  end

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  logic uses_rs_early;   // rs is needed in ID (BEQ, BNE, JR)
  logic uses_rt_early;   // rt is needed in ID (BEQ, BNE)
  logic load_use;
  logic br_ex_haz;
  logic br_mem_haz;
  logic haz;

  assign uses_rs_early = is_beq || is_bne || is_jr;
  assign uses_rt_early = is_beq || is_bne;

  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == rs_idx) || (ex_dest == rt_idx));

  // Any producer still in EX has no result reachable from ID yet.
  assign br_ex_haz = ex_reg_write && (ex_dest != '0) &&
                     ((uses_rs_early && (ex_dest == rs_idx)) ||
                      (uses_rt_early && (ex_dest == rt_idx)));

  // A load in MEM has not read memory yet. It reaches ID through the
  // write-through bypass one cycle later.
  assign br_mem_haz = mem_mem_read && (mem_dest != '0) &&
                      ((uses_rs_early && (mem_dest == rs_idx)) ||
                       (uses_rt_early && (mem_dest == rt_idx)));

  assign haz        = in_valid && (load_use || br_ex_haz || br_mem_haz);
  assign stall_flag = haz || in_hold;

  // -------------------------------------------------------------------------
  // Early branch / jump resolution
  // -------------------------------------------------------------------------
  logic [len-1:0] br_target;
  logic [len-1:0] jmp_target;

  assign br_target  = in_pc_branch + {sext_imm[len-3:0], 2'b00};
  assign jmp_target = {in_pc_branch[len-1:28], imm26, 2'b00};

  // NOTE: every output of a combinational block gets a default on entry, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = '0;
    if (in_valid && !stall_flag) begin
      if ((is_beq && (fwd_rs == fwd_rt)) || (is_bne && (fwd_rs != fwd_rt))) begin
        redirect        = 1'b1;
        redirect_target = br_target;
      end else if (is_j || is_jal) begin
        redirect        = 1'b1;
        redirect_target = jmp_target;
      end else if (is_jr) begin
        redirect        = 1'b1;
        redirect_target = fwd_rs;
      end
    end
  end

  // -------------------------------------------------------------------------
  // ID/EX register: flush > hold > hazard bubble > normal load
  // -------------------------------------------------------------------------
  idex_t idex_q;
  idex_t idex_d;

  always_comb begin
    idex_d = idex_q;
    if (in_flush) begin
      idex_d = '0;
    end else if (in_hold) begin
      idex_d = idex_q;
    end else if (haz) begin
      idex_d = '0;
    end else begin
      idex_d.valid       = in_valid;
      idex_d.pc_branch   = in_pc_branch;
      // EX forwarding takes care of these, so the un-forwarded file values
      // are latched here.
      idex_d.reg1        = rf_rs;
      idex_d.reg2        = rf_rt;
      idex_d.sign_extend = sext_imm;
      idex_d.rs          = rs_idx;
      idex_d.rt          = rt_idx;
      idex_d.rd          = rd_idx;
      idex_d.shamt       = shamt_f;
      idex_d.exec_bus    = in_valid ? in_exec_bus : '0;
      idex_d.mem_bus     = in_valid ? in_mem_bus  : '0;
      idex_d.wb_bus      = in_valid ? in_wb_bus   : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign out_valid       = idex_q.valid;
  assign out_pc_branch   = idex_q.pc_branch;
  assign out_reg1        = idex_q.reg1;
  assign out_reg2        = idex_q.reg2;
  assign out_sign_extend = idex_q.sign_extend;
  assign out_rs          = idex_q.rs;
  assign out_rt          = idex_q.rt;
  assign out_rd          = idex_q.rd;
  assign out_shamt       = idex_q.shamt;
  assign execute_bus     = idex_q.exec_bus;
  assign memory_bus      = idex_q.mem_bus;
  assign writeBack_bus   = idex_q.wb_bus;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage. Inputs change 1 ns after a rising edge.
// Combinational outputs are checked 1 ns after the inputs settle. Registered
// outputs are checked 1 ns after the next rising edge.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  localparam int LEN = 32;
  localparam int NB  = 5;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [LEN-1:0]  in_pc_branch;
  logic [LEN-1:0]  in_instruccion;
  logic [10:0]     in_exec_bus;
  logic [8:0]      in_mem_bus;
  logic [1:0]      in_wb_bus;
  logic            in_hold;
  logic            in_flush;
  logic            RegWrite;
  logic [NB-1:0]   write_register;
  logic [LEN-1:0]  write_data;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [NB-1:0]   ex_dest;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic [NB-1:0]   mem_dest;
  logic [LEN-1:0]  mem_fwd_data;
  logic            out_valid;
  logic [LEN-1:0]  out_pc_branch;
  logic [LEN-1:0]  out_reg1;
  logic [LEN-1:0]  out_reg2;
  logic [LEN-1:0]  out_sign_extend;
  logic [NB-1:0]   out_rs;
  logic [NB-1:0]   out_rt;
  logic [NB-1:0]   out_rd;
  logic [NB-1:0]   out_shamt;
  logic [10:0]     execute_bus;
  logic [8:0]      memory_bus;
  logic [1:0]      writeBack_bus;
  logic            stall_flag;
  logic            redirect;
  logic [LEN-1:0]  redirect_target;

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_pc_branch    (in_pc_branch),
    .in_instruccion  (in_instruccion),
    .in_exec_bus     (in_exec_bus),
    .in_mem_bus      (in_mem_bus),
    .in_wb_bus       (in_wb_bus),
    .in_hold         (in_hold),
    .in_flush        (in_flush),
    .RegWrite        (RegWrite),
    .write_register  (write_register),
    .write_data      (write_data),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_dest         (ex_dest),
    .mem_reg_write   (mem_reg_write),
    .mem_mem_read    (mem_mem_read),
    .mem_dest        (mem_dest),
    .mem_fwd_data    (mem_fwd_data),
    .out_valid       (out_valid),
    .out_pc_branch   (out_pc_branch),
    .out_reg1        (out_reg1),
    .out_reg2        (out_reg2),
    .out_sign_extend (out_sign_extend),
    .out_rs          (out_rs),
    .out_rt          (out_rt),
    .out_rd          (out_rd),
    .out_shamt       (out_shamt),
    .execute_bus     (execute_bus),
    .memory_bus      (memory_bus),
    .writeBack_bus   (writeBack_bus),
    .stall_flag      (stall_flag),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-encoded instructions
  localparam logic [31:0] ADD_R4_R3_R3 = 32'h0063_2020;  // add r4,r3,r3
  localparam logic [31:0] ADD_R6_R0_R3 = 32'h0003_3020;  // add r6,r0,r3
  localparam logic [31:0] ADD_R9_R8_R1 = 32'h0101_4820;  // add r9,r8,r1
  localparam logic [31:0] ADD_R6_R5_R0 = 32'h00A0_3020;  // add r6,r5,r0
  localparam logic [31:0] BEQ_R2_R2_P4 = 32'h1042_0004;  // beq r2,r2,+4
  localparam logic [31:0] BNE_R2_R2_P4 = 32'h1442_0004;  // bne r2,r2,+4
  localparam logic [31:0] BEQ_R2_R2_M1 = 32'h1042_FFFF;  // beq r2,r2,-1
  localparam logic [31:0] BEQ_R7_R0_P8 = 32'h10E0_0008;  // beq r7,r0,+8
  localparam logic [31:0] J_123456     = 32'h0812_3456;  // j 0x123456
  localparam logic [31:0] JR_R3        = 32'h0060_0008;  // jr r3

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_dest       = '0;
    mem_reg_write = 1'b0;
    mem_mem_read  = 1'b0;
    mem_dest      = '0;
    mem_fwd_data  = '0;
  endtask

  initial begin
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_pc_branch   = '0;
    in_instruccion = '0;
    in_exec_bus    = '0;
    in_mem_bus     = '0;
    in_wb_bus      = '0;
    in_hold        = 1'b0;
    in_flush       = 1'b0;
    RegWrite       = 1'b0;
    write_register = '0;
    write_data     = '0;
    clear_hazards();
    #2;

    // Reset state
    check("reset_valid",    32'(out_valid), 32'd0);
    check("reset_reg1",     out_reg1, 32'd0);
    check("reset_stall",    32'(stall_flag), 32'd0);
    check("reset_redirect", 32'(redirect), 32'd0);

    tick();
    reset = 1'b1;

    // Preload r7 = 5 and r5 = 0x77 with no instruction in ID
    RegWrite = 1'b1; write_register = 5'd7; write_data = 32'd5;
    tick();
    write_register = 5'd5; write_data = 32'h77;
    tick();

    // Write r3 = 0xAA while decoding add r4,r3,r3 (write-through bypass)
    write_register = 5'd3; write_data = 32'hAA;
    in_valid = 1'b1; in_instruccion = ADD_R4_R3_R3; in_pc_branch = 32'h40;
    in_exec_bus = 11'h123; in_mem_bus = 9'h0A5; in_wb_bus = 2'b10;
    #1;
    check("wt_stall", 32'(stall_flag), 32'd0);
    tick();
    check("wt_valid", 32'(out_valid), 32'd1);
    check("wt_reg1",  out_reg1, 32'hAA);
    check("wt_reg2",  out_reg2, 32'hAA);
    check("wt_rs",    32'(out_rs), 32'd3);
    check("wt_rd",    32'(out_rd), 32'd4);
    check("wt_pc",    out_pc_branch, 32'h40);
    check("wt_exbus", 32'(execute_bus), 32'h123);
    check("wt_mbus",  32'(memory_bus), 32'h0A5);
    check("wt_wbbus", 32'(writeBack_bus), 32'h2);

    // A write to r0 is neither bypassed nor stored
    write_register = 5'd0; write_data = 32'h55; in_instruccion = ADD_R6_R0_R3;
    tick();
    check("r0_bypass", out_reg1, 32'd0);
    RegWrite = 1'b0;
    tick();
    check("r0_stored", out_reg1, 32'd0);
    check("r3_stored", out_reg2, 32'hAA);

    // Load-use: lw r8 in EX, add r9,r8,r1 in ID
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd8;
    in_instruccion = ADD_R9_R8_R1;
    #1;
    check("lu_stall", 32'(stall_flag), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(out_valid), 32'd0);
    check("lu_bubble_exbus", 32'(execute_bus), 32'd0);
    check("lu_bubble_wbbus", 32'(writeBack_bus), 32'd0);
    // Load moves to MEM; a non-branch does not stall on it
    clear_hazards();
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dest = 5'd8;
    #1;
    check("lu_release", 32'(stall_flag), 32'd0);
    tick();
    check("lu_add_valid", 32'(out_valid), 32'd1);
    check("lu_add_rd",    32'(out_rd), 32'd9);
    clear_hazards();

    // Branch resolution with no hazards
    in_pc_branch = 32'h100; in_instruccion = BEQ_R2_R2_P4;
    #1;
    check("beq_redirect", 32'(redirect), 32'd1);
    check("beq_target",   redirect_target, 32'h110);
    in_instruccion = BNE_R2_R2_P4;
    #1;
    check("bne_redirect", 32'(redirect), 32'd0);
    check("bne_target",   redirect_target, 32'd0);
    in_instruccion = BEQ_R2_R2_M1;
    #1;
    check("beq_neg_target", redirect_target, 32'hFC);

    // beq r7,r0 with r7 = 5 in the file but 0 forwarded from MEM
    in_instruccion = BEQ_R7_R0_P8;
    mem_reg_write = 1'b1; mem_dest = 5'd7; mem_fwd_data = 32'd0;
    #1;
    check("fwd_redirect", 32'(redirect), 32'd1);
    check("fwd_target",   redirect_target, 32'h120);
    check("fwd_stall",    32'(stall_flag), 32'd0);
    mem_reg_write = 1'b0;
    #1;
    check("nofwd_redirect", 32'(redirect), 32'd0);

    // ALU producer of r7 in EX stalls the branch
    ex_reg_write = 1'b1; ex_dest = 5'd7;
    #1;
    check("alu_br_stall",    32'(stall_flag), 32'd1);
    check("alu_br_redirect", 32'(redirect), 32'd0);

    // Load producer of r7: two stall cycles, then the value arrives via write-back
    ex_mem_read = 1'b1;
    #1;
    check("ld_br_stall1",    32'(stall_flag), 32'd1);
    check("ld_br_redirect1", 32'(redirect), 32'd0);
    tick();
    check("ld_br_bubble1", 32'(out_valid), 32'd0);
    clear_hazards();
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dest = 5'd7;
    #1;
    check("ld_br_stall2",    32'(stall_flag), 32'd1);
    check("ld_br_redirect2", 32'(redirect), 32'd0);
    tick();
    check("ld_br_bubble2", 32'(out_valid), 32'd0);
    clear_hazards();
    RegWrite = 1'b1; write_register = 5'd7; write_data = 32'd0;
    #1;
    check("ld_br_stall3",    32'(stall_flag), 32'd0);
    check("ld_br_redirect3", 32'(redirect), 32'd1);
    check("ld_br_target3",   redirect_target, 32'h120);
    tick();
    RegWrite = 1'b0;
    check("ld_br_latched", 32'(out_valid), 32'd1);

    // J and JR
    in_instruccion = J_123456; in_pc_branch = 32'hA000_0100;
    #1;
    check("j_redirect", 32'(redirect), 32'd1);
    check("j_target",   redirect_target, 32'hA048_D158);
    in_instruccion = JR_R3;
    #1;
    check("jr_target", redirect_target, 32'hAA);
    ex_reg_write = 1'b1; ex_dest = 5'd3;
    #1;
    check("jr_stall",    32'(stall_flag), 32'd1);
    check("jr_redirect", 32'(redirect), 32'd0);
    clear_hazards();

    // Hold for three cycles with changing instructions, then flush during hold
    in_instruccion = ADD_R4_R3_R3; in_pc_branch = 32'h200; in_exec_bus = 11'h456;
    tick();
    check("hold_pre_pc", out_pc_branch, 32'h200);
    in_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instruccion = ADD_R9_R8_R1 + 32'(i);
      in_pc_branch   = 32'h300 + 32'(i * 4);
      in_exec_bus    = 11'h7F0 + 11'(i);
      #1;
      check("hold_stall", 32'(stall_flag), 32'd1);
      tick();
      check("hold_pc",    out_pc_branch, 32'h200);
      check("hold_rd",    32'(out_rd), 32'd4);
      check("hold_exbus", 32'(execute_bus), 32'h456);
    end
    in_flush = 1'b1;
    tick();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_exbus", 32'(execute_bus), 32'd0);
    in_hold = 1'b0; in_flush = 1'b0;

    // Reset mid-run takes effect without a clock edge
    in_instruccion = ADD_R4_R3_R3; in_pc_branch = 32'h400;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_reg1",  out_reg1, 32'd0);
    check("rst_async_pc",    out_pc_branch, 32'd0);
    tick();
    reset = 1'b1;
    in_instruccion = ADD_R6_R5_R0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_r5",    out_reg1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
